alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares the single combinational ALU between two requesters, e.g. the execute stage (req0)
//   and the branch/address unit (req1). Each requester has a valid/ready request channel and a
//   valid/ready response channel.
//   - Round-robin arbitration on conflict; at most one ALU operation per cycle.
//   - Operands and op are muxed to the ALU combinationally; the result is registered.
//   - Each requester has a one-deep response buffer.
// PARAMETERS
//   DATA_W  32  operand/result width; must equal ALU width
//   CTRL_W   4  ALU control width; must match `ALU_* encodings
//   CNT_W   16  width of statistics counters (ALU_ARB_STATS_EN only)
// PORTS
//   clk            in   1       rising-edge clock (single clock domain)
//   rst_n          in   1       asynchronous active-low reset
//   reqN_valid     in   1       N in {0,1}: request present
//   reqN_ready     out  1       request accepted this cycle (comb.)
//   reqN_op        in   CTRL_W  ALU operation (`ALU_* encoding)
//   reqN_a         in   DATA_W  operand A
//   reqN_b         in   DATA_W  operand B
//   rspN_valid     out  1       registered result available
//   rspN_ready     in   1       requester consumes result
//   rspN_result    out  DATA_W  registered ALU result
//   rspN_zero      out  1       registered ALU zero flag
//   alu_operand_a  out  DATA_W  to ALU operand_a
//   alu_operand_b  out  DATA_W  to ALU operand_b
//   alu_control    out  CTRL_W  to ALU alu_control
//   alu_result     in   DATA_W  from ALU
//   alu_zero       in   1       from ALU
// BEHAVIOUR
//   - Reset values: rspN_valid=0, rspN_result=0, rspN_zero=0, last_grant=1 (req0 wins the first
//     conflict), stats counters=0. Reset asserted mid-operation discards pending results.
//   - Eligibility: reqN is eligible when reqN_valid && (!rspN_valid || rspN_ready). A same-cycle
//     drain frees the slot.
//   - Grant:
//     - One eligible requester: it is granted.
//     - Both eligible: the requester != last_grant is granted.
//     - last_grant updates only on a grant.
//   - reqN_ready = grantN (combinational). Requesters hold op/a/b stable while valid && !ready.
//   - ALU drive:
//     - While a grant is active, drive the granted op/a/b.
//     - With no grant, drive a=0, b=0, control=`ALU_ADD.
//   - Latency: grant in cycle N; rspN_valid=1 with result/zero captured at the end of N is
//     visible in cycle N+1.
//   - Response hold: rspN_result/zero/valid stay stable until rspN_valid && rspN_ready.
//     - On the handshake, with no new grant to N in the same cycle, rspN_valid clears at the
//       next edge.
//     - With a new grant, rspN_valid stays 1 and the data is replaced.
//   - Throughput: one op per cycle total. With both requesters continuously valid and both
//     responses always ready, grants alternate 0,1,0,1...
//   - Blocked: if both responses are full and not draining, no grant and the ALU is idle.
//   - An undefined op is passed through unchanged. The ALU yields 0, so rsp result=0, zero=1.
// CONFIGURATION
//   ALU_ARB_STATS_EN defined:
//     - Adds outputs grant0_cnt, grant1_cnt, conflict_cnt (CNT_W each).
//     - grantN_cnt increments on each grant to N.
//     - conflict_cnt increments when both requesters are eligible in the same cycle.
//     - All counters wrap modulo 2^CNT_W and are reset to 0.
//   ALU_ARB_STATS_EN undefined: the counter ports and logic are absent; behaviour is otherwise
//   identical.
// TESTING
//   1. Single op: req0 ADD a=5,b=7, rsp0_ready=1 -> req0_ready same cycle; next cycle
//      rsp0_valid=1, rsp0_result=12, rsp0_zero=0.
//   2. Conflict after reset: both valid, req0 SUB 9-9, req1 SLT -1<1 -> req0 granted first
//      (result 0, zero=1), req1 next cycle (result 1).
//   3. Backpressure: rsp0_ready=0 with rsp0 full and req0 valid -> req0_ready=0, rsp0 data
//      stable.
//      - Raise rsp0_ready -> drain and new grant in the same cycle; rsp0_valid stays 1 with
//        new data.
//   4. Streaming: both valid 8 cycles, responses always ready -> grants 0,1,0,1,...; 4 results
//      each, in order.
//   5. Reset mid-op: assert rst_n=0 while rsp1_valid=1 -> rsp1_valid=0 immediately (async);
//      after release the next conflict grants req0.
//   6. ALU_ARB_STATS_EN with CNT_W=4: 17 grants to req0 -> grant0_cnt=1 (wrap);
//      conflict_cnt matches the count of both-eligible cycles.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// One requester's request/response channel pair on the shared-ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [CTRL_W-1:0] req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a
// registered one-deep response slot each. Define ALU_ARB_STATS_EN for grant/conflict counters.
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif

module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   req0,
    alu_share_arbiter_if.slave   req1,
    output logic [DATA_W-1:0]    alu_operand_a,
    output logic [DATA_W-1:0]    alu_operand_b,
    output logic [CTRL_W-1:0]    alu_control,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]     grant0_cnt,
    output logic [CNT_W-1:0]     grant1_cnt,
    output logic [CNT_W-1:0]     conflict_cnt
`endif
);

    if (DATA_W < 1 || CTRL_W < 4 || CNT_W < 1) begin : g_bad_params
    end

    logic [1:0]        valid;
    logic [1:0]        rsp_ready;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_zero;
    logic [CTRL_W-1:0] op [2];
    logic [DATA_W-1:0] opa [2];
    logic [DATA_W-1:0] opb [2];
    logic [DATA_W-1:0] rsp_result [2];
    logic              last_grant_reg;

    assign valid     = {req1.req_valid, req0.req_valid};
    assign rsp_ready = {req1.rsp_ready, req0.rsp_ready};
    assign op[0]     = req0.req_op;
    assign op[1]     = req1.req_op;
    assign opa[0]    = req0.req_a;
    assign opa[1]    = req1.req_a;
    assign opb[0]    = req0.req_b;
    assign opb[1]    = req1.req_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic              valid_reg;
            logic [DATA_W-1:0] result_reg;
            logic              zero_reg;

            // A response being consumed this cycle frees the slot for a new grant.
            assign elig[gi] = valid[gi] && (!valid_reg || rsp_ready[gi]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg  <= 1'b0;
                    result_reg <= '0;
                    zero_reg   <= 1'b0;
                end else if (grant[gi]) begin
                    valid_reg  <= 1'b1;
                    result_reg <= alu_result;
                    zero_reg   <= alu_zero;
                end else if (rsp_ready[gi]) begin
                    valid_reg  <= 1'b0;
                end
            end

            assign rsp_valid[gi]  = valid_reg;
            assign rsp_result[gi] = result_reg;
            assign rsp_zero[gi]   = zero_reg;
        end
    endgenerate

    // On conflict the requester that did not win last time goes first.
    assign grant[0] = elig[0] && (!elig[1] || last_grant_reg);
    assign grant[1] = elig[1] && (!elig[0] || !last_grant_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (|grant) begin
            last_grant_reg <= grant[1];
        end
    end

    always_comb begin
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_control   = CTRL_W'(`ALU_ADD);
        if (grant[0]) begin
            alu_operand_a = opa[0];
            alu_operand_b = opb[0];
            alu_control   = op[0];
        end else if (grant[1]) begin
            alu_operand_a = opa[1];
            alu_operand_b = opb[1];
            alu_control   = op[1];
        end
    end

    assign req0.req_ready  = grant[0];
    assign req1.req_ready  = grant[1];
    assign req0.rsp_valid  = rsp_valid[0];
    assign req1.rsp_valid  = rsp_valid[1];
    assign req0.rsp_result = rsp_result[0];
    assign req1.rsp_result = rsp_result[1];
    assign req0.rsp_zero   = rsp_zero[0];
    assign req1.rsp_zero   = rsp_zero[1];

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant0_cnt_reg;
    logic [CNT_W-1:0] grant1_cnt_reg;
    logic [CNT_W-1:0] conflict_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt_reg   <= '0;
            grant1_cnt_reg   <= '0;
            conflict_cnt_reg <= '0;
        end else begin
            if (grant[0]) grant0_cnt_reg <= grant0_cnt_reg + 1'b1;
            if (grant[1]) grant1_cnt_reg <= grant1_cnt_reg + 1'b1;
            if (&elig)    conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
        end
    end

    assign grant0_cnt   = grant0_cnt_reg;
    assign grant1_cnt   = grant1_cnt_reg;
    assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU stand-in.
// Build with +define+ALU_ARB_STATS_EN to also exercise the statistics counters.
`timescale 1ns/1ps

module tb_alu_share_arbiter;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
`ifdef ALU_ARB_STATS_EN
    logic [3:0]  grant0_cnt;
    logic [3:0]  grant1_cnt;
    logic [3:0]  conflict_cnt;
`endif

    int n_checks;
    int n_pass;
    int j0;
    int j1;

    alu_share_arbiter_if #(.DATA_W(32), .CTRL_W(4)) r0 ();
    alu_share_arbiter_if #(.DATA_W(32), .CTRL_W(4)) r1 ();

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0          (r0),
        .req1          (r1),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_control   (alu_control),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant0_cnt    (grant0_cnt),
        .grant1_cnt    (grant1_cnt),
        .conflict_cnt  (conflict_cnt)
`endif
    );

    always_comb begin
        case (alu_control)
            OP_AND:  alu_result = alu_operand_a & alu_operand_b;
            OP_OR:   alu_result = alu_operand_a | alu_operand_b;
            OP_ADD:  alu_result = alu_operand_a + alu_operand_b;
            OP_SUB:  alu_result = alu_operand_a - alu_operand_b;
            OP_SLT:  alu_result = ($signed(alu_operand_a) < $signed(alu_operand_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && r0.req_ready)
            $display("[%0t] grant req0 op=%h a=%h b=%h", $time, r0.req_op, r0.req_a, r0.req_b);
        if (rst_n && r1.req_ready)
            $display("[%0t] grant req1 op=%h a=%h b=%h", $time, r1.req_op, r1.req_a, r1.req_b);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        r0.req_valid = v; r0.req_op = o; r0.req_a = a; r0.req_b = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        r1.req_valid = v; r1.req_op = o; r1.req_a = a; r1.req_b = b;
    endtask

    task automatic do_reset();
        drive0(1'b0, OP_ADD, 32'd0, 32'd0);
        drive1(1'b0, OP_ADD, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;
        do_reset();
        check("rst rsp0_valid",  32'(r0.rsp_valid), 32'd0);
        check("rst rsp0_result", r0.rsp_result, 32'd0);
        check("rst rsp0_zero",   32'(r0.rsp_zero), 32'd0);
        check("rst rsp1_valid",  32'(r1.rsp_valid), 32'd0);
        check("rst rsp1_result", r1.rsp_result, 32'd0);
        check("rst rsp1_zero",   32'(r1.rsp_zero), 32'd0);
`ifdef ALU_ARB_STATS_EN
        check("rst grant0_cnt",   32'(grant0_cnt), 32'd0);
        check("rst conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif

        // Single ADD on req0
        drive0(1'b1, OP_ADD, 32'd5, 32'd7);
        @(negedge clk);
        check("t1 req0_ready", 32'(r0.req_ready), 32'd1);
        check("t1 req1_ready", 32'(r1.req_ready), 32'd0);
        check("t1 alu_control", 32'(alu_control), 32'(OP_ADD));
        check("t1 alu_a", alu_operand_a, 32'd5);
        check("t1 alu_b", alu_operand_b, 32'd7);
        tick();
        r0.req_valid = 1'b0;
        check("t1 rsp0_valid",  32'(r0.rsp_valid), 32'd1);
        check("t1 rsp0_result", r0.rsp_result, 32'd12);
        check("t1 rsp0_zero",   32'(r0.rsp_zero), 32'd0);
        @(negedge clk);
        check("idle alu_control", 32'(alu_control), 32'(OP_ADD));
        check("idle alu_a", alu_operand_a, 32'd0);
        check("idle req0_ready", 32'(r0.req_ready), 32'd0);
        tick();
        check("t1 rsp0 drained", 32'(r0.rsp_valid), 32'd0);

        // Undefined op passes straight through; the ALU gives 0
        drive1(1'b1, 4'hF, 32'd3, 32'd4);
        @(negedge clk);
        check("undef req1_ready", 32'(r1.req_ready), 32'd1);
        check("undef alu_control", 32'(alu_control), 32'hF);
        tick();
        r1.req_valid = 1'b0;
        check("undef rsp1_valid",  32'(r1.rsp_valid), 32'd1);
        check("undef rsp1_result", r1.rsp_result, 32'd0);
        check("undef rsp1_zero",   32'(r1.rsp_zero), 32'd1);
        tick();

        // Conflict after reset: req0 first
        do_reset();
        drive0(1'b1, OP_SUB, 32'd9, 32'd9);
        drive1(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        check("t2 req0_ready", 32'(r0.req_ready), 32'd1);
        check("t2 req1_ready", 32'(r1.req_ready), 32'd0);
        tick();
        r0.req_valid = 1'b0;
        check("t2 rsp0_result", r0.rsp_result, 32'd0);
        check("t2 rsp0_zero",   32'(r0.rsp_zero), 32'd1);
        @(negedge clk);
        check("t2 req1_ready", 32'(r1.req_ready), 32'd1);
        tick();
        r1.req_valid = 1'b0;
        check("t2 rsp1_result", r1.rsp_result, 32'd1);
        check("t2 rsp1_zero",   32'(r1.rsp_zero), 32'd0);
        tick();

        // Backpressure on rsp0 then drain + regrant in the same cycle
        r0.rsp_ready = 1'b0;
        drive0(1'b1, OP_OR, 32'hF0, 32'h0F);
        tick();
        drive0(1'b1, OP_AND, 32'hFF, 32'h3C);
        check("t3 rsp0_valid",  32'(r0.rsp_valid), 32'd1);
        check("t3 rsp0_result", r0.rsp_result, 32'hFF);
        @(negedge clk);
        check("t3 req0_ready blocked", 32'(r0.req_ready), 32'd0);
        check("t3 alu_a idle", alu_operand_a, 32'd0);
        tick();
        check("t3 rsp0_result held", r0.rsp_result, 32'hFF);
        r0.rsp_ready = 1'b1;
        @(negedge clk);
        check("t3 req0_ready drain", 32'(r0.req_ready), 32'd1);
        tick();
        r0.req_valid = 1'b0;
        check("t3 rsp0_valid kept", 32'(r0.rsp_valid), 32'd1);
        check("t3 rsp0_result new", r0.rsp_result, 32'h3C);
        tick();
        check("t3 rsp0 drained", 32'(r0.rsp_valid), 32'd0);

        // Both response slots full and not draining: nobody is granted
        r0.rsp_ready = 1'b0;
        r1.rsp_ready = 1'b0;
        drive1(1'b1, OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        check("blk req1_ready first", 32'(r1.req_ready), 32'd1);
        tick();
        drive1(1'b1, OP_ADD, 32'd2, 32'd2);
        drive0(1'b1, OP_ADD, 32'd3, 32'd3);
        @(negedge clk);
        check("blk req0_ready", 32'(r0.req_ready), 32'd1);
        check("blk req1_ready full", 32'(r1.req_ready), 32'd0);
        tick();
        @(negedge clk);
        check("blk both req0_ready", 32'(r0.req_ready), 32'd0);
        check("blk both req1_ready", 32'(r1.req_ready), 32'd0);
        check("blk alu_a idle", alu_operand_a, 32'd0);
        tick();
        check("blk rsp0_result", r0.rsp_result, 32'd6);
        check("blk rsp1_result", r1.rsp_result, 32'd2);
        r0.req_valid = 1'b0;
        r1.req_valid = 1'b0;
        r0.rsp_ready = 1'b1;
        r1.rsp_ready = 1'b1;
        tick();
        check("blk rsp0 drained", 32'(r0.rsp_valid), 32'd0);
        check("blk rsp1 drained", 32'(r1.rsp_valid), 32'd0);

        // Streaming: grants alternate starting with req0, results in order
        do_reset();
        j0 = 0;
        j1 = 0;
        for (int k = 0; k < 8; k++) begin
            drive0(1'b1, OP_ADD, 32'(j0 + 1), 32'd100);
            drive1(1'b1, OP_SUB, 32'd100, 32'(j1));
            @(negedge clk);
            check($sformatf("t4[%0d] req0_ready", k), 32'(r0.req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t4[%0d] req1_ready", k), 32'(r1.req_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (k % 2 == 0) begin
                check($sformatf("t4[%0d] rsp0_result", k), r0.rsp_result, 32'(j0 + 101));
                j0++;
            end else begin
                check($sformatf("t4[%0d] rsp1_result", k), r1.rsp_result, 32'(100 - j1));
                j1++;
            end
        end
        r0.req_valid = 1'b0;
        r1.req_valid = 1'b0;
        tick();

        // Reset mid-op with rsp1 full and last grant on req0
        r1.rsp_ready = 1'b0;
        drive1(1'b1, OP_ADD, 32'd10, 32'd20);
        tick();
        r1.req_valid = 1'b0;
        drive0(1'b1, OP_ADD, 32'd1, 32'd2);
        tick();
        r0.req_valid = 1'b0;
        check("t5 rsp1_valid before", 32'(r1.rsp_valid), 32'd1);
        check("t5 rsp1_result before", r1.rsp_result, 32'd30);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 rsp1_valid async", 32'(r1.rsp_valid), 32'd0);
        check("t5 rsp1_result async", r1.rsp_result, 32'd0);
        tick();
        rst_n = 1'b1;
        r1.rsp_ready = 1'b1;
        drive0(1'b1, OP_ADD, 32'd4, 32'd4);
        drive1(1'b1, OP_ADD, 32'd5, 32'd5);
        @(negedge clk);
        check("t5 req0_ready", 32'(r0.req_ready), 32'd1);
        check("t5 req1_ready", 32'(r1.req_ready), 32'd0);
        tick();
        r0.req_valid = 1'b0;
        tick();
        r1.req_valid = 1'b0;
        tick();

`ifdef ALU_ARB_STATS_EN
        // Counter wrap and conflict counting with 4-bit counters
        do_reset();
        drive0(1'b1, OP_ADD, 32'd1, 32'd1);
        repeat (17) tick();
        r0.req_valid = 1'b0;
        check("t6 grant0_cnt wrap", 32'(grant0_cnt), 32'd1);
        check("t6 grant1_cnt", 32'(grant1_cnt), 32'd0);
        check("t6 conflict_cnt none", 32'(conflict_cnt), 32'd0);
        drive0(1'b1, OP_ADD, 32'd1, 32'd1);
        drive1(1'b1, OP_ADD, 32'd2, 32'd2);
        repeat (3) tick();
        r0.req_valid = 1'b0;
        r1.req_valid = 1'b0;
        check("t6 conflict_cnt", 32'(conflict_cnt), 32'd3);
        check("t6 grant0_cnt", 32'(grant0_cnt), 32'd2);
        check("t6 grant1_cnt after", 32'(grant1_cnt), 32'd2);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
